// File: rtl/wysw_pkg.sv
// ---------------------------------------------------------------------------
// wysw_pkg
//
// Shared definitions for the 4-digit multiplexed 7-segment display
// controller (sterownik_wyswietlacza) and its binary-to-BCD engine
// (bin2bcd_seq).
//
// Contents:
//   DIGIT_W, NDIG      - digit width and digit count of the display
//   BIN_W, BCD_W       - width of the binary input and of the packed BCD word
//   MAX_VAL            - largest value the four digits can show (9999)
//   N_ITER             - number of shift-add-3 iterations (one per input bit)
//   stan_t             - controller FSM state encoding
//   E_PAT              - active-low digit-enable pattern for each scan index
//   dodaj3()           - "add 3 to every nibble >= 5" correction step
// ---------------------------------------------------------------------------
package wysw_pkg;

    localparam int DIGIT_W = 4;
    localparam int NDIG    = 4;
    localparam int BIN_W   = 14;
    localparam int BCD_W   = DIGIT_W * NDIG;

    localparam logic [BIN_W-1:0] MAX_VAL = 14'd9999;
    localparam logic [3:0]       N_ITER  = 4'd14;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } stan_t;

    // Scan index 0 drives the leftmost digit (thousands), index 3 the units.
    localparam logic [NDIG-1:0][NDIG-1:0] E_PAT = {
        4'b0111,
        4'b1011,
        4'b1101,
        4'b1110
    };

    // Double-dabble correction: any BCD nibble that would overflow past 9
    // after the next left shift gets 3 added now, so the shift carries it
    // into the next decade correctly.
    function automatic logic [BCD_W-1:0] dodaj3(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] wynik;
        wynik = bcd;
        for (int i = 0; i < NDIG; i++) begin
            if (wynik[i*DIGIT_W +: DIGIT_W] >= 4'd5) begin
                wynik[i*DIGIT_W +: DIGIT_W] = wynik[i*DIGIT_W +: DIGIT_W] + 4'd3;
            end
        end
        return wynik;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
//
// Sequential binary-to-BCD converter using the shift-add-3 (double dabble)
// algorithm: one correction+shift per clock-enabled cycle, 14 iterations per
// conversion, no dividers. Values above 9999 are clamped to 9999 on capture
// and the clamp is reported alongside the result.
//
// Ports:
//   CLK      in   clock, rising edge
//   CLR      in   asynchronous active-low reset
//   CE       in   clock enable; all engine state holds when low
//   start    in   capture bin_in and begin a conversion (sampled with CE)
//   bin_in   in   14-bit binary value
//   last     out  the final iteration happens on the next CE edge
//   bcd      out  BCD accumulator (thousands [15:12] .. units [3:0])
//   clamped  out  captured value exceeded 9999 and was clamped
// ---------------------------------------------------------------------------
module bin2bcd_seq
    import wysw_pkg::*;
(
    input  logic             CLK,
    input  logic             CLR,
    input  logic             CE,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_in,
    output logic             last,
    output logic [BCD_W-1:0] bcd,
    output logic             clamped
);

    logic [BIN_W-1:0] sh_bin;
    logic [BCD_W-1:0] sh_bcd;
    logic [3:0]       cnt;
    logic             clamp_r;
    logic             za_duzo;

    assign za_duzo = (bin_in > MAX_VAL);

    // Capture on start, then iterate while the counter is non-zero.
    // The correction is applied to the BCD half before the combined
    // {bcd, bin} word is shifted left by one, so the MSB of the binary
    // half walks into the units nibble on every iteration.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            sh_bin  <= '0;
            sh_bcd  <= '0;
            cnt     <= '0;
            clamp_r <= 1'b0;
        end else if (CE) begin
            if (start) begin
                sh_bin  <= za_duzo ? MAX_VAL : bin_in;
                sh_bcd  <= '0;
                cnt     <= N_ITER;
                clamp_r <= za_duzo;
            end else if (cnt != 4'd0) begin
                {sh_bcd, sh_bin} <= {dodaj3(sh_bcd), sh_bin} << 1;
                cnt              <= cnt - 4'd1;
            end
        end
    end

    // The controller uses this to step to its commit state on the same edge
    // as the final iteration, so the result is ready one CE edge later.
    assign last    = (cnt == 4'd1);
    assign bcd     = sh_bcd;
    assign clamped = clamp_r;

endmodule

// File: rtl/sterownik_wyswietlacza.sv
// ---------------------------------------------------------------------------
// sterownik_wyswietlacza
//
// Sequencing controller for the 4-digit multiplexed 7-segment display.
// Accepts a 14-bit value through a LOAD handshake, converts it to BCD with
// the bin2bcd_seq engine, commits the digits into a display register and
// time-multiplexes the four active-low digit enables with a prescaler.
// Optional leading-zero blanking hides zero thousands/hundreds/tens digits.
// DIGIT feeds the konw7seg encoder directly.
//
// Parameters:
//   PRESC_DIV   CE-qualified clock cycles per digit slot (>= 2)
//   BLANK_LZ    1 = blank leading zeros (units digit is never blanked)
//
// Ports:
//   CLK    in   clock, rising edge
//   CLR    in   asynchronous active-low reset
//   CE     in   clock enable; FSM, engine, prescaler and scan index hold
//   LOAD   in   conversion request, accepted in IDLE with CE=1
//   IN     in   14-bit binary value, captured on LOAD acceptance
//   BUSY   out  conversion in progress
//   DONE   out  one-cycle pulse when a new value is committed
//   OVF    out  last committed value was clamped to 9999
//   E      out  active-low digit enables
//   DIGIT  out  BCD digit of the active slot
//   BLANK  out  active slot is blanked
// ---------------------------------------------------------------------------
module sterownik_wyswietlacza
    import wysw_pkg::*;
#(
    parameter int unsigned PRESC_DIV = 50000,
    parameter bit          BLANK_LZ  = 1'b1
) (
    input  logic               CLK,
    input  logic               CLR,
    input  logic               CE,
    input  logic               LOAD,
    input  logic [BIN_W-1:0]   IN,
    output logic               BUSY,
    output logic               DONE,
    output logic               OVF,
    output logic [NDIG-1:0]    E,
    output logic [DIGIT_W-1:0] DIGIT,
    output logic               BLANK
);

    localparam int              PW         = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESC_DIV - 1);

    stan_t              stan;
    logic               busy_r;
    logic               done_r;
    logic               ovf_r;
    logic [BCD_W-1:0]   disp_bcd;

    logic               start;
    logic               eng_last;
    logic [BCD_W-1:0]   eng_bcd;
    logic               eng_clamp;

    logic [PW-1:0]      presc;
    logic [1:0]         idx;

    logic [DIGIT_W-1:0] tysiace;
    logic [DIGIT_W-1:0] setki;
    logic [DIGIT_W-1:0] dziesiatki;
    logic [DIGIT_W-1:0] jednosci;
    logic               wygas;
    logic [DIGIT_W-1:0] cyfra;

    // A request is only forwarded to the engine while idle, so LOAD pulses
    // during a conversion are dropped rather than queued.
    assign start = (stan == IDLE) && LOAD;

    bin2bcd_seq u_bin2bcd (
        .CLK     (CLK),
        .CLR     (CLR),
        .CE      (CE),
        .start   (start),
        .bin_in  (IN),
        .last    (eng_last),
        .bcd     (eng_bcd),
        .clamped (eng_clamp)
    );

    // Controller FSM and display register. DONE is updated outside the CE
    // gate so the pulse always lasts exactly one CLK cycle, even when CE
    // drops right after the commit. BUSY is registered together with the
    // state so it rises on the accepting edge and falls on the commit edge.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            stan     <= IDLE;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            ovf_r    <= 1'b0;
            disp_bcd <= '0;
        end else begin
            done_r <= CE && (stan == COMMIT);
            if (CE) begin
                unique case (stan)
                    IDLE: begin
                        if (LOAD) begin
                            stan   <= CONV;
                            busy_r <= 1'b1;
                        end
                    end
                    CONV: begin
                        if (eng_last) begin
                            stan <= COMMIT;
                        end
                    end
                    COMMIT: begin
                        disp_bcd <= eng_bcd;
                        ovf_r    <= eng_clamp;
                        stan     <= IDLE;
                        busy_r   <= 1'b0;
                    end
                    default: begin
                        stan   <= IDLE;
                        busy_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign BUSY = busy_r;
    assign DONE = done_r;
    assign OVF  = ovf_r;

    // Slot prescaler and scan index. The index only advances on the
    // prescaler's terminal count, and both freeze together when CE is low,
    // so every slot lasts exactly PRESC_DIV enabled cycles.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            presc <= '0;
            idx   <= 2'd0;
        end else if (CE) begin
            if (presc == PRESC_LAST) begin
                presc <= '0;
                idx   <= idx + 2'd1;
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

    assign tysiace    = disp_bcd[15:12];
    assign setki      = disp_bcd[11:8];
    assign dziesiatki = disp_bcd[7:4];
    assign jednosci   = disp_bcd[3:0];

    // Digit select and leading-zero blanking, decoded purely from idx and
    // the display register so a commit and an idx advance on the same edge
    // show the new value in the new slot with no stale cycle. A slot is a
    // leading zero only if it and every more significant digit are zero.
    always_comb begin
        cyfra = jednosci;
        wygas = 1'b0;
        unique case (idx)
            2'd0: begin
                cyfra = tysiace;
                wygas = BLANK_LZ && (tysiace == 4'd0);
            end
            2'd1: begin
                cyfra = setki;
                wygas = BLANK_LZ && (tysiace == 4'd0) && (setki == 4'd0);
            end
            2'd2: begin
                cyfra = dziesiatki;
                wygas = BLANK_LZ && (tysiace == 4'd0) && (setki == 4'd0)
                        && (dziesiatki == 4'd0);
            end
            default: begin
                cyfra = jednosci;
                wygas = 1'b0;
            end
        endcase
    end

    assign DIGIT = cyfra;
    assign BLANK = wygas;
    assign E     = wygas ? 4'b1111 : E_PAT[idx];

endmodule

// File: tb/tb_sterownik_wyswietlacza.sv
// ---------------------------------------------------------------------------
// tb_sterownik_wyswietlacza
//
// Directed bench for the display controller with PRESC_DIV=4, BLANK_LZ=1.
// Inputs change on the falling edge; outputs are sampled on the falling
// edge, away from the active rising edge. The expected scan pattern comes
// from a count of enabled clock edges since reset release plus the digits
// each step expects to be on the display.
// ---------------------------------------------------------------------------
module tb_sterownik_wyswietlacza;

    localparam int PRESC = 4;
    localparam bit BLZ   = 1'b1;

    logic        CLK;
    logic        CLR;
    logic        CE;
    logic        LOAD;
    logic [13:0] IN;
    logic        BUSY;
    logic        DONE;
    logic        OVF;
    logic [3:0]  E;
    logic [3:0]  DIGIT;
    logic        BLANK;

    int compared   = 0;
    int mismatched = 0;
    int ceCount    = 0;

    sterownik_wyswietlacza #(
        .PRESC_DIV (PRESC),
        .BLANK_LZ  (BLZ)
    ) dut (
        .CLK   (CLK),
        .CLR   (CLR),
        .CE    (CE),
        .LOAD  (LOAD),
        .IN    (IN),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .OVF   (OVF),
        .E     (E),
        .DIGIT (DIGIT),
        .BLANK (BLANK)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Enabled clock edges since reset release; the slot index is derived
    // from this count.
    always @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            ceCount <= 0;
        end else if (CE) begin
            ceCount <= ceCount + 1;
        end
    end

    // Expected {E, DIGIT, BLANK} for a given enabled-edge count and display.
    function automatic logic [8:0] expScan(input int cnt, input logic [15:0] d);
        int         idx;
        logic [3:0] dg;
        logic       bl;
        logic [3:0] en;
        idx = (cnt / PRESC) % 4;
        dg  = d[(3 - idx) * 4 +: 4];
        case (idx)
            0:       bl = BLZ && (d[15:12] == 4'd0);
            1:       bl = BLZ && (d[15:8] == 8'd0);
            2:       bl = BLZ && (d[15:4] == 12'd0);
            default: bl = 1'b0;
        endcase
        en = bl ? 4'b1111 : ~(4'b0001 << idx);
        return {en, dg, bl};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkScan(input logic [15:0] d, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge CLK);
            checkOutput($sformatf("scan_%04h_%0d", d, i), 32'({E, DIGIT, BLANK}),
                        32'(expScan(ceCount, d)));
        end
    endtask

    // One-cycle LOAD, then wait (bounded) for DONE. latency is the number of
    // rising edges after the accepting edge at which DONE is first seen.
    task automatic applyStimulus(input logic [13:0] value, output int latency);
        @(negedge CLK);
        IN   = value;
        LOAD = 1'b1;
        @(negedge CLK);
        LOAD = 1'b0;
        checkOutput($sformatf("busy_after_load_%0d", value), 32'(BUSY), 32'd1);
        latency = -1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge CLK);
            if (DONE) begin
                latency = n;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int lat2;
        int ceEdges;
        int cyc;
        int doneSeen;

        CLR  = 1'b0;
        CE   = 1'b1;
        LOAD = 1'b0;
        IN   = '0;
        $display("[TB] start");

        repeat (3) @(negedge CLK);
        checkOutput("rst_E",     32'(E),     32'hF);
        checkOutput("rst_BLANK", 32'(BLANK), 32'd1);
        checkOutput("rst_BUSY",  32'(BUSY),  32'd0);
        checkOutput("rst_DONE",  32'(DONE),  32'd0);
        checkOutput("rst_OVF",   32'(OVF),   32'd0);
        checkOutput("rst_DIGIT", 32'(DIGIT), 32'd0);
        CLR = 1'b1;
        checkScan(16'h0000, 16);

        // 1234: latency and full scan
        applyStimulus(14'd1234, lat);
        checkOutput("lat_1234", 32'(lat), 32'd15);
        checkOutput("ovf_1234", 32'(OVF), 32'd0);
        @(negedge CLK);
        checkOutput("done_pulse_1234", 32'(DONE), 32'd0);
        checkOutput("busy_idle_1234",  32'(BUSY), 32'd0);
        checkScan(16'h1234, 16);

        // leading-zero blanking
        applyStimulus(14'd7, lat);
        checkOutput("lat_7", 32'(lat), 32'd15);
        checkScan(16'h0007, 16);
        applyStimulus(14'd0, lat);
        checkOutput("lat_0", 32'(lat), 32'd15);
        checkScan(16'h0000, 16);

        // clamp and its clearing
        applyStimulus(14'd12000, lat);
        checkOutput("lat_12000", 32'(lat), 32'd15);
        checkOutput("ovf_12000", 32'(OVF), 32'd1);
        checkScan(16'h9999, 16);
        applyStimulus(14'd5, lat);
        checkOutput("ovf_5", 32'(OVF), 32'd0);
        checkScan(16'h0005, 16);

        // LOAD during BUSY ignored; LOAD in the DONE cycle accepted
        @(negedge CLK);
        IN   = 14'd42;
        LOAD = 1'b1;
        @(negedge CLK);
        LOAD = 1'b0;
        checkOutput("busy_42", 32'(BUSY), 32'd1);
        lat = -1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge CLK);
            if (DONE) begin
                lat = c;
                break;
            end
            if (c == 4) begin
                IN   = 14'd99;
                LOAD = 1'b1;
            end
            if (c == 5) begin
                LOAD = 1'b0;
            end
        end
        checkOutput("lat_42", 32'(lat), 32'd15);
        IN   = 14'd99;
        LOAD = 1'b1;
        @(negedge CLK);
        LOAD = 1'b0;
        checkOutput("done_single_42", 32'(DONE), 32'd0);
        checkOutput("busy_99",        32'(BUSY), 32'd1);
        checkScan(16'h0042, 12);
        lat2 = -1;
        for (int c = 14; c <= 200; c++) begin
            @(negedge CLK);
            if (DONE) begin
                lat2 = c;
                break;
            end
        end
        checkOutput("lat_99_from_done", 32'(lat2), 32'd16);
        checkScan(16'h0099, 16);

        // CE toggling every cycle during the conversion of 8765
        @(negedge CLK);
        IN   = 14'd8765;
        LOAD = 1'b1;
        CE   = 1'b1;
        @(negedge CLK);
        LOAD    = 1'b0;
        CE      = 1'b0;
        ceEdges = 0;
        cyc     = -1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge CLK);
            if (CE) ceEdges++;
            @(negedge CLK);
            if (DONE) begin
                cyc = c;
                break;
            end
            checkOutput("ce_scan_frozen", 32'({E, DIGIT, BLANK}),
                        32'(expScan(ceCount, 16'h0099)));
            CE = ~CE;
        end
        checkOutput("ce_iter_edges", 32'(ceEdges), 32'd15);
        checkOutput("ce_total_cyc",  32'(cyc),     32'd30);
        CE = 1'b0;
        @(negedge CLK);
        checkOutput("done_ce0", 32'(DONE), 32'd0);
        CE = 1'b1;
        checkScan(16'h8765, 16);

        // reset in the middle of a conversion
        applyStimulus(14'd12000, lat);
        checkOutput("ovf_pre_rst", 32'(OVF), 32'd1);
        @(negedge CLK);
        IN   = 14'd1234;
        LOAD = 1'b1;
        @(negedge CLK);
        LOAD = 1'b0;
        repeat (5) @(negedge CLK);
        CLR = 1'b0;
        #1;
        checkOutput("mid_rst_E",     32'(E),     32'hF);
        checkOutput("mid_rst_BLANK", 32'(BLANK), 32'd1);
        checkOutput("mid_rst_BUSY",  32'(BUSY),  32'd0);
        checkOutput("mid_rst_DONE",  32'(DONE),  32'd0);
        checkOutput("mid_rst_OVF",   32'(OVF),   32'd0);
        checkOutput("mid_rst_DIGIT", 32'(DIGIT), 32'd0);
        @(negedge CLK);
        CLR      = 1'b1;
        doneSeen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (DONE) doneSeen++;
        end
        checkOutput("no_done_after_rst", 32'(doneSeen), 32'd0);
        checkScan(16'h0000, 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sterownik_wyswietlacza.md
# sterownik_wyswietlacza

Sequencing controller for the 4-digit multiplexed 7-segment display. It accepts a 14-bit binary value through a load handshake and converts it to BCD with a sequential shift-add-3 engine, so no dividers are needed. It holds the committed digits in a display register and time-multiplexes the four digit enables with a programmable prescaler, with optional leading-zero blanking. It sits between the measurement/counter logic and the 7-segment encoder (konw7seg); DIGIT feeds the encoder directly.

## Interface
- PRESC_DIV, 50000: CE-qualified CLK cycles per digit slot (≥2).
- BLANK_LZ, 1: 1 = blank leading zeros in thousands/hundreds/tens; units never blanked.

- CLK  in  1  clock, all state on rising edge.
- CLR  in  1  reset; one clock, asynchronous, active-low.
- CE  in  1  clock enable; when low, all state (FSM, shift engine, prescaler, digit index) holds.
- LOAD  in  1  conversion request, sampled when CE=1.
- IN  in  14  binary value, captured on LOAD acceptance.
- BUSY  out  1  conversion in progress.
- DONE  out  1  one-cycle pulse: new value committed to display.
- OVF  out  1  last committed value was clamped.
- E  out  4  active-low digit enables.
- DIGIT  out  4  BCD digit for the active slot.
- BLANK  out  1  active slot is blanked.

## Operation
- FSM states: IDLE, CONV, COMMIT.
- IDLE → CONV on LOAD=1 & CE=1:
  - Capture min(IN, 9999) into the shift register.
  - Latch clamp flag = (IN > 9999).
  - Clear the BCD accumulator and load iteration counter = 14.
- CONV, each CE cycle: add 3 to every BCD nibble ≥5, then shift {bcd, bin} left by 1 and decrement the counter. Go to COMMIT when the counter reaches 0 (14 iterations).
- COMMIT, one CE cycle:
  - disp_bcd ← accumulator (16 bit: thousands in [15:12] … units in [3:0]).
  - OVF ← clamp flag.
  - Return to IDLE.
- LOAD while BUSY=1 is ignored (not queued). The display keeps showing the old value throughout conversion.
- Scan:
  - Prescaler counts CE cycles 0..PRESC_DIV-1. At terminal count it wraps to 0 and the 2-bit idx increments, wrapping 3→0.
  - idx→E/DIGIT: 0→1110/thousands, 1→1101/hundreds, 2→1011/tens, 3→0111/units.
- Blanking with BLANK_LZ=1:
  - Thousands is blanked if 0.
  - Hundreds is blanked if thousands and hundreds are both 0.
  - Tens is blanked if thousands, hundreds and tens are all 0.
  - In a blanked slot: E=1111, BLANK=1, DIGIT still carries the digit (0).
- E, DIGIT and BLANK are decoded combinationally from the registers idx and disp_bcd only.

## Timing
- Reset (CLR=0), asynchronous:
  - State: FSM=IDLE, shift state=0, prescaler=0, idx=0, disp_bcd=0.
  - Outputs: BUSY=0, DONE=0, OVF=0, DIGIT=0. With BLANK_LZ=1: E=1111, BLANK=1; otherwise E=1110, BLANK=0.
- Reset mid-conversion aborts it: no DONE, display shows 0.
- Latency, CE held 1 and LOAD accepted at edge k:
  - BUSY=1 after edge k.
  - Iterations occur on edges k+1..k+14.
  - Commit happens at edge k+15: BUSY=0, DONE=1 for exactly one cycle, new disp_bcd and OVF visible.
- With CE gaps, latency stretches by the number of CE=0 cycles. DONE still lasts exactly one CLK cycle, and DONE deasserts even if CE=0 in the following cycle.
- LOAD=1 in the DONE cycle is accepted (FSM is IDLE). Back-to-back throughput is one value per 16 cycles.
- A commit coinciding with a prescaler wrap: idx advance and disp_bcd update take effect on the same edge. The new slot shows the new value.
- Digit slot period is PRESC_DIV CE cycles; full refresh is 4·PRESC_DIV.

## Structure
- Shared package wysw_pkg:
  - constants DIGIT_W=4, NDIG=4, MAX_VAL=14'd9999;
  - the FSM state encoding;
  - the 4-entry idx→E pattern constant.
- One sub-module: bin2bcd_seq. It contains the shift-add-3 engine, iteration counter, start/done handshake and clamp. The top holds the FSM glue, display register, prescaler, scan and blanking.
- krazace_zero is not reused; the scan index is local so that blanking and idx stay coherent.

## Test plan
- Reset: CLR=0 mid-run with BLANK_LZ=1 → E=1111, BLANK=1, BUSY=0, DONE=0, OVF=0 immediately, without waiting for a clock edge. First slot after release shows idx 0.
- LOAD with IN=1234, CE=1 → DONE at edge k+15. Scan yields E 1110/1101/1011/0111 with DIGIT 1,2,3,4, each held PRESC_DIV cycles (use PRESC_DIV=4).
- IN=7 with BLANK_LZ=1 → thousands, hundreds and tens slots give E=1111, BLANK=1; units slot gives E=0111, DIGIT=7. IN=0 → only units shown, DIGIT=0.
- IN=12000 → display 9,9,9,9 and OVF=1. Next LOAD with IN=5 → OVF=0 after commit.
- LOAD pulsed again during BUSY (IN=42, then 99 at k+5) → only 42 is committed, single DONE. LOAD=1 in the DONE cycle with IN=99 → accepted, DONE 16 cycles later.
- CE toggling 1/0 every cycle during conversion → DONE arrives after 14 iterations counted on CE=1 cycles only. Scan and FSM are frozen on CE=0 cycles. Result is unchanged.
